// File: rtl/rv_plic_core.sv
// rv_plic_core: PLIC gateways with saturating edge counters and per-target priority arbitration
module rv_plic_core #(
  parameter int NumSrc = 64,
  parameter int NumTarget = 2,
  parameter int MaxPrio = 7,
  parameter int EdgeCntW = 4,
  localparam int PRIOW = $clog2(MaxPrio + 1),
  localparam int SRCW = $clog2(NumSrc)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumSrc-1:0]                    src_i,
  input  logic [NumSrc-1:0]                    le_i,
  input  logic [NumSrc-1:0][PRIOW-1:0]         prio_i,
  input  logic [NumTarget-1:0][NumSrc-1:0]     ie_i,
  input  logic [NumTarget-1:0][PRIOW-1:0]      threshold_i,
  input  logic [NumTarget-1:0]                 claim_i,
  input  logic [NumTarget-1:0]                 complete_i,
  input  logic [NumTarget-1:0][SRCW-1:0]       complete_id_i,
  input  logic                                 ovf_clr_i,
  output logic [NumSrc-1:0]                    ip_o,
  output logic [NumTarget-1:0]                 irq_o,
  output logic [NumTarget-1:0][SRCW-1:0]       irq_id_o,
  output logic [NumSrc-1:0]                    edge_ovf_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, ACT = 2'd2} gw_e;
  localparam logic [NumSrc-1:0] Live = {{(NumSrc-1){1'b1}}, 1'b0};
  localparam logic [EdgeCntW-1:0] CntMax = '1;
  gw_e st_q [NumSrc];
  gw_e st_d [NumSrc];
  logic [EdgeCntW-1:0] cnt_q [NumSrc];
  logic [EdgeCntW-1:0] cnt_d [NumSrc];
  logic [NumSrc-1:0] src_q, le_q, ovf_q, ovf_d, ovf_set;
  logic [NumSrc-1:0] edge_s, pend_req, consume, claim_hit, comp_hit;
  logic [NumTarget-1:0] irq_q, irq_d;
  logic [NumTarget-1:0][SRCW-1:0] id_q, id_d;

  // state register: gateway FSMs, counters, input history and arbitration results
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q <= '0;
      le_q  <= '0;
      ovf_q <= '0;
      irq_q <= '0;
      id_q  <= '0;
      for (int s = 0; s < NumSrc; s++) begin
        st_q[s]  <= IDLE;
        cnt_q[s] <= '0;
      end
    end else begin
      src_q <= src_i;
      le_q  <= le_i;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
      id_q  <= id_d;
      for (int s = 0; s < NumSrc; s++) begin
        st_q[s]  <= st_d[s];
        cnt_q[s] <= cnt_d[s];
      end
    end
  end

  // decode claim/complete strobes into per-source hits; ID 0 never hits
  always_comb begin
    claim_hit = '0;
    comp_hit  = '0;
    for (int s = 0; s < NumSrc; s++)
      for (int t = 0; t < NumTarget; t++) begin
        claim_hit[s] = claim_hit[s] | (Live[s] & claim_i[t] & (irq_id_o[t] == SRCW'(s)));
        comp_hit[s]  = comp_hit[s] | (Live[s] & complete_i[t] & (complete_id_i[t] == SRCW'(s)));
      end
  end

  // pending requests: level follows the line, edge mode drains the backlog counter
  always_comb begin
    edge_s = src_i & ~src_q & le_q & Live;
    pend_req = '0;
    consume  = '0;
    for (int s = 0; s < NumSrc; s++) begin
      pend_req[s] = Live[s] & (le_q[s] ? (edge_s[s] | (cnt_q[s] != '0)) : src_i[s]);
      consume[s]  = (st_q[s] == IDLE) & pend_req[s];
    end
  end

  // next-state logic for each gateway FSM
  always_comb begin
    for (int s = 0; s < NumSrc; s++) begin
      st_d[s] = IDLE;
      case (st_q[s])
        IDLE:    st_d[s] = pend_req[s] ? PEND : IDLE;
        PEND:    st_d[s] = claim_hit[s] ? ACT : PEND;
        ACT:     st_d[s] = comp_hit[s] ? IDLE : ACT;
        default: st_d[s] = IDLE;
      endcase
      if (!Live[s]) st_d[s] = IDLE;
    end
  end

  // edge backlog counters saturate at all-ones and flag the lost edge
  always_comb begin
    ovf_set = '0;
    for (int s = 0; s < NumSrc; s++) begin
      ovf_set[s] = edge_s[s] & ~consume[s] & (cnt_q[s] == CntMax);
      cnt_d[s] = !le_q[s] ? '0 :
                 (edge_s[s] & ~consume[s]) ? ((cnt_q[s] == CntMax) ? cnt_q[s] : cnt_q[s] + EdgeCntW'(1)) :
                 (~edge_s[s] & consume[s]) ? cnt_q[s] - EdgeCntW'(1) : cnt_q[s];
    end
    ovf_d = (ovf_clr_i ? '0 : ovf_q) | ovf_set;
  end

  // gateway outputs: a source is visible to arbitration only while pending
  always_comb begin
    ip_o = '0;
    for (int s = 0; s < NumSrc; s++) ip_o[s] = (st_q[s] == PEND);
  end

  // per-target arbitration: strict compare in ascending ID order keeps the lowest ID on ties
  always_comb begin
    irq_d = '0;
    id_d  = '0;
    for (int t = 0; t < NumTarget; t++) begin
      logic [PRIOW-1:0] bp;
      logic [SRCW-1:0] bi;
      bp = '0;
      bi = '0;
      for (int s = 0; s < NumSrc; s++)
        if (ip_o[s] && ie_i[t][s] && prio_i[s] > bp) begin
          bp = prio_i[s];
          bi = SRCW'(s);
        end
      id_d[t]  = bi;
      irq_d[t] = bp > threshold_i[t];
    end
  end

  assign irq_o      = irq_q;
  assign irq_id_o   = id_q;
  assign edge_ovf_o = ovf_q;
endmodule

// File: tb/tb_rv_plic_core.sv
// tb_rv_plic_core: directed self-checking bench for rv_plic_core
module tb_rv_plic_core;
  logic clk, rst, ovf_clr;
  logic [15:0] src, le, ip, ovf;
  logic [15:0][2:0] prio;
  logic [1:0][15:0] ie;
  logic [1:0][2:0] thr;
  logic [1:0] claim, complete, irq;
  logic [1:0][3:0] cid, id;
  int total, bad;

  rv_plic_core #(.NumSrc(16), .NumTarget(2), .MaxPrio(7), .EdgeCntW(2)) dut (
    .clk_i(clk), .rst_i(rst), .src_i(src), .le_i(le), .prio_i(prio), .ie_i(ie),
    .threshold_i(thr), .claim_i(claim), .complete_i(complete), .complete_id_i(cid),
    .ovf_clr_i(ovf_clr), .ip_o(ip), .irq_o(irq), .irq_id_o(id), .edge_ovf_o(ovf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in;
    src = '0; le = '0; prio = '0; ie = '0; thr = '0;
    claim = '0; complete = '0; cid = '0; ovf_clr = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    clear_in();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic pulse(input int s);
    src[s] = 1;
    tick();
    src[s] = 0;
    tick();
  endtask

  task automatic deliver(input int t, input logic [3:0] sid, input string tag);
    chk(tag, 32'(id[t]), 32'(sid));
    claim[t] = 1;
    tick();
    claim[t] = 0;
    tick();
    complete[t] = 1;
    cid[t] = sid;
    tick();
    complete[t] = 0;
    tick();
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1;
    clear_in();
    tick();
    chk("rst_ip", 32'(ip), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_id", 32'(id), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 0;

    // level source, single target
    do_reset();
    prio[5] = 3; ie[0][5] = 1; src[5] = 1;
    tick();
    chk("lvl_ip_n1", 32'(ip[5]), 1);
    chk("lvl_irq_n1", 32'(irq[0]), 0);
    tick();
    chk("lvl_irq_n2", 32'(irq[0]), 1);
    chk("lvl_id_n2", 32'(id[0]), 5);
    claim[0] = 1;
    tick();
    claim[0] = 0;
    chk("lvl_claim_ip", 32'(ip[5]), 0);
    chk("lvl_claim_id_stale", 32'(id[0]), 5);
    tick();
    chk("lvl_claim_id", 32'(id[0]), 0);
    chk("lvl_claim_irq", 32'(irq[0]), 0);
    complete[0] = 1; cid[0] = 5;
    tick();
    complete[0] = 0;
    chk("lvl_cmp_idle", 32'(ip[5]), 0);
    tick();
    chk("lvl_cmp_repend", 32'(ip[5]), 1);

    // priority, tie-break and threshold
    do_reset();
    prio[3] = 4; prio[9] = 4; prio[12] = 2;
    ie[0] = 16'h1208; ie[1] = 16'h1000; src = 16'h1208;
    tick();
    tick();
    chk("tie_id", 32'(id[0]), 3);
    chk("tie_irq", 32'(irq[0]), 1);
    chk("t1_id", 32'(id[1]), 12);
    prio[9] = 5;
    tick();
    chk("prio_up_id", 32'(id[0]), 9);
    thr[0] = 4;
    tick();
    chk("thr_below_irq", 32'(irq[0]), 1);
    thr[0] = 5;
    tick();
    chk("thr_equal_irq", 32'(irq[0]), 0);
    chk("thr_equal_id", 32'(id[0]), 9);

    // edge burst of three pulses
    do_reset();
    le[7] = 1; prio[7] = 1; ie[0][7] = 1;
    tick();
    pulse(7);
    pulse(7);
    pulse(7);
    chk("burst_ip", 32'(ip[7]), 1);
    deliver(0, 4'd7, "burst_d1");
    deliver(0, 4'd7, "burst_d2");
    deliver(0, 4'd7, "burst_d3");
    chk("burst_drained_ip", 32'(ip[7]), 0);
    chk("burst_drained_id", 32'(id[0]), 0);

    // counter saturation and sticky overflow
    do_reset();
    le[7] = 1; prio[7] = 1; ie[0][7] = 1;
    tick();
    pulse(7);
    claim[0] = 1;
    tick();
    claim[0] = 0;
    for (int i = 0; i < 5; i++) pulse(7);
    chk("ovf_set", 32'(ovf), 32'h0080);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("ovf_clr", 32'(ovf), 0);
    src[7] = 1; ovf_clr = 1;
    tick();
    src[7] = 0; ovf_clr = 0;
    tick();
    chk("ovf_set_wins", 32'(ovf), 32'h0080);
    complete[0] = 1; cid[0] = 7;
    tick();
    complete[0] = 0;
    tick();
    tick();
    deliver(0, 4'd7, "sat_d1");
    deliver(0, 4'd7, "sat_d2");
    deliver(0, 4'd7, "sat_d3");
    chk("sat_drained_ip", 32'(ip[7]), 0);

    // two targets, ignored completes and claims
    do_reset();
    prio[4] = 2; prio[6] = 1; ie[0] = 16'h0050; ie[1] = 16'h0010; src[4] = 1; src[6] = 1;
    tick();
    tick();
    chk("two_id0", 32'(id[0]), 4);
    chk("two_id1", 32'(id[1]), 4);
    claim = 2'b11;
    tick();
    claim = 2'b00;
    chk("two_claim_ip", 32'(ip), 32'h0040);
    tick();
    chk("two_id0_next", 32'(id[0]), 6);
    chk("two_id1_none", 32'(id[1]), 0);
    complete[1] = 1; cid[1] = 4;
    tick();
    complete[1] = 0;
    chk("t1_cmp_idle", 32'(ip[4]), 0);
    tick();
    chk("t1_cmp_repend", 32'(ip[4]), 1);
    complete[0] = 1; cid[0] = 6;
    tick();
    complete[0] = 0;
    tick();
    chk("cmp_pending_ignored", 32'(ip[6]), 1);
    ie[1] = '0;
    tick();
    tick();
    chk("no_cand_id", 32'(id[1]), 0);
    claim[1] = 1;
    tick();
    claim[1] = 0;
    chk("claim_id0_ignored", 32'(ip), 32'h0050);

    // asynchronous reset during an edge backlog
    do_reset();
    le[7] = 1; prio[7] = 1; ie[0][7] = 1; prio[5] = 3; ie[0][5] = 1;
    tick();
    pulse(7);
    claim[0] = 1;
    tick();
    claim[0] = 0;
    pulse(7);
    pulse(7);
    src[5] = 1;
    tick();
    tick();
    chk("pre_rst_id", 32'(id[0]), 5);
    chk("pre_rst_ip", 32'(ip), 32'h0020);
    #2;
    rst = 1;
    #1;
    chk("async_rst_ip", 32'(ip), 0);
    chk("async_rst_irq", 32'(irq), 0);
    chk("async_rst_id", 32'(id), 0);
    src = '0;
    tick();
    rst = 0;
    tick();
    tick();
    tick();
    chk("post_rst_ip", 32'(ip), 0);
    chk("post_rst_irq", 32'(irq), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_plic_core.md
# rv_plic_core

Parametrised interrupt core for the next-generation PLIC: per-source gateways plus per-target priority arbitration, sized by parameters rather than hard-coded for 64 sources and 1 target. It sits between the raw interrupt lines and the PLIC register block. The register block supplies priorities, enables, thresholds and claim/complete strobes. Edge-triggered sources gain a saturating pending-edge counter, so bursts of edges are not lost, with a sticky overflow flag per source.

## Interface
- NumSrc, 64: number of sources including reserved ID 0; ≥2.
- NumTarget, 2: number of interrupt targets (harts/contexts); ≥1.
- MaxPrio, 7: highest priority value; PRIOW = $clog2(MaxPrio+1).
- EdgeCntW, 4: width of each edge pending counter; saturates at 2^EdgeCntW−1.
- SRCW (derived) = $clog2(NumSrc).

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  async active-high reset.
- src_i  in  NumSrc  raw interrupt lines; bit 0 ignored.
- le_i  in  NumSrc  trigger mode: 0 level, 1 edge.
- prio_i  in  [NumSrc][PRIOW]  source priority; 0 = never interrupts.
- ie_i  in  [NumTarget][NumSrc]  per-target enables.
- threshold_i  in  [NumTarget][PRIOW]  per-target threshold.
- claim_i  in  NumTarget  single-cycle claim strobe; claims current irq_id_o[t].
- complete_i  in  NumTarget  single-cycle complete strobe.
- complete_id_i  in  [NumTarget][SRCW]  ID being completed.
- ovf_clr_i  in  1  clears all overflow flags.
- ip_o  out  NumSrc  pending bits (to IP registers).
- irq_o  out  NumTarget  interrupt request per target.
- irq_id_o  out  [NumTarget][SRCW]  winning ID per target; 0 = none.
- edge_ovf_o  out  NumSrc  sticky edge-counter overflow.

## Operation
- Per source s≥1, gateway FSM: IDLE → PENDING → ACTIVE → IDLE. Source 0 stays IDLE; ip_o[0]=0, cnt[0]=0.
- Level mode: pend_req = src_i[s].
- Edge mode: edge = src_i[s] & ~src_q[s], where src_q is registered src_i. pend_req = edge | (cnt≠0).
- IDLE & pend_req → PENDING; ip_o[s]=1 in PENDING only.
- PENDING & claim of s by any target → ACTIVE. Multiple targets claiming s in the same cycle produce one transition.
- ACTIVE & complete of s by any target → IDLE. Complete for a non-ACTIVE source is ignored. Claim for a non-PENDING source or for ID 0 is ignored.
- Edge counter update: cnt_next = cnt + edge − (IDLE & pend_req & (cnt≠0 | edge) consumed).
  - Edges during PENDING/ACTIVE accumulate.
  - Edge plus consume in the same cycle leaves cnt unchanged.
- Saturation: cnt at max with an edge and no consume keeps cnt at max and sets edge_ovf_o[s].
- edge_ovf_o clears only on ovf_clr_i. If ovf_clr_i and a new overflow occur in the same cycle, set wins.
- Level mode forces cnt to 0.
- le_i changes take effect next cycle. FSM state is preserved across a mode change.
- Target t arbitration over sources with ip & ie_i[t] & (prio≠0):
  - winner = highest prio; ties go to the lowest ID.
  - irq_id_o[t] = winner, or 0 if no candidate.
  - irq_o[t] = candidate exists & winner prio > threshold_i[t].

## Timing
- Reset: all gateways IDLE, cnt=0, src_q=0, ip_o=0, edge_ovf_o=0, irq_o=0, irq_id_o=0.
- src_i rise at cycle n → ip_o at n+1 → irq_o/irq_id_o registered at n+2.
- claim_i at n → ip_o falls at n+1 → irq_id_o updates at n+2.
  - A repeated claim at n+1 carries the stale ID and is ignored by the gateway.
  - Software sequencing guarantees ≥2 cycles between claims per target.
- complete_i at n → IDLE at n+1. If pend_req still holds, the source re-enters PENDING at n+2 and ip_o rises at n+2.
- Claim and complete of the same ID in the same cycle:
  - PENDING: claim applies, complete is ignored.
  - ACTIVE: complete applies.
- Reset asserted mid-operation returns every state and output to reset values asynchronously.
- Priority, enable and threshold changes reflect in irq_o one cycle later.

## Test plan
- Level, single target: src 5 high, prio 3, ie set, threshold 0 → ip_o[5] at +1, irq_o=1 and irq_id_o=5 at +2. Claim → ip_o[5]=0. Complete with src still high → ip_o[5]=1 two cycles later.
- Priority/tie: sources 3 and 9 prio 4, source 12 prio 2 → irq_id_o=3. Raise prio9 to 5 → irq_id_o=9 next cycle. Threshold 5 → irq_o=0, irq_id_o stays 9.
- Edge burst: 3 pulses on source 7 before claim → three claim/complete cycles each deliver ID 7, then ip_o[7]=0 and cnt=0.
- Overflow: EdgeCntW=2, 5 edges while ACTIVE → cnt=3, edge_ovf_o[7]=1. ovf_clr_i → 0. Simultaneous clear and new overflow → stays 1.
- Two targets: both claim ID 4 in the same cycle → single ACTIVE. Complete from target 1 → IDLE. Complete for IDLE ID 6 → no change. Claim with irq_id_o=0 → no change.
- Reset mid-burst: rst_i while cnt=2 and ACTIVE → all outputs 0 immediately, no pending after release.
